// File: rtl/router_pkg.sv
// router_pkg: shared sizes, port index type and per-output state encoding for the router.
//   NPORT       number of input and output ports
//   AW          port index width, clog2(NPORT)
//   port_id_t   AW-bit port index
//   out_state_e per-output lock state {IDLE, BUSY}
package router_pkg;
   localparam int NPORT = 16;
   localparam int AW = 4;
   typedef logic [AW-1:0] port_id_t;
   typedef enum logic {IDLE, BUSY} out_state_e;
endpackage

// File: rtl/router_rr_arb.sv
// router_rr_arb: combinational round-robin pick of the first candidate at or after ptr.
//   cand      candidate inputs for one output
//   ptr       highest-priority input index
//   gnt       one-hot winner
//   gnt_idx   winner index
//   gnt_valid at least one candidate present
module router_rr_arb import router_pkg::*; (
   input  logic [NPORT-1:0] cand,
   input  port_id_t         ptr,
   output logic [NPORT-1:0] gnt,
   output port_id_t         gnt_idx,
   output logic             gnt_valid
);
   logic [NPORT-1:0] rot;
   port_id_t off;
   // rotate so ptr lands on bit 0, then take the lowest set bit as the offset from ptr
   always_comb begin
      rot = NPORT'({cand, cand} >> ptr);
      off = '0;
      for (int k = NPORT-1; k >= 0; k--) if (rot[k]) off = port_id_t'(k);
      gnt_valid = |cand;
      gnt_idx = ptr + off;
      gnt = gnt_valid ? (NPORT'(1) << gnt_idx) : '0;
   end
endmodule

// File: rtl/router_xbar_sched.sv
// router_xbar_sched: per-output round-robin crossbar scheduler with packet-length grant lock.
//   clk       router clock
//   reset_n   asynchronous active-low reset
//   req       input i waiting for or holding an output
//   req_dst   destination of input i in [i*AW +: AW]
//   done      end-of-packet pulse from input i
//   grant     input i owns an output
//   out_busy  output o is locked
//   sel       owning input of output o in [o*AW +: AW]
module router_xbar_sched import router_pkg::*; (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NPORT-1:0]    req,
   input  logic [NPORT*AW-1:0] req_dst,
   input  logic [NPORT-1:0]    done,
   output logic [NPORT-1:0]    grant,
   output logic [NPORT-1:0]    out_busy,
   output logic [NPORT*AW-1:0] sel
);
   out_state_e [NPORT-1:0] state_q, state_d;
   port_id_t [NPORT-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
   logic [NPORT-1:0][NPORT-1:0] cand, pick_oh;
   logic [NPORT-1:0] pick_valid, grant_d;
   // an already-granted input is masked so it cannot be picked twice
   always_comb begin
      for (int o = 0; o < NPORT; o++)
         for (int i = 0; i < NPORT; i++)
            cand[o][i] = req[i] && req_dst[i*AW +: AW] == port_id_t'(o) && !grant[i];
   end
   for (genvar g = 0; g < NPORT; g++) begin : g_arb
      router_rr_arb u_arb (
         .cand      (cand[g]),
         .ptr       (ptr_q[g]),
         .gnt       (pick_oh[g]),
         .gnt_idx   (pick_idx[g]),
         .gnt_valid (pick_valid[g])
      );
   end
   // release only takes effect next edge, so a waiting candidate sees one idle cycle
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d = ptr_q;
      grant_d = grant;
      for (int o = 0; o < NPORT; o++) begin
         if (state_q[o] == IDLE && pick_valid[o]) begin
            state_d[o] = BUSY;
            owner_d[o] = pick_idx[o];
            ptr_d[o] = pick_idx[o] + 1'b1;
            grant_d = grant_d | pick_oh[o];
         end else if (state_q[o] == BUSY && done[owner_q[o]]) begin
            state_d[o] = IDLE;
            grant_d[owner_q[o]] = 1'b0;
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= {NPORT{IDLE}};
         owner_q <= '0;
         ptr_q <= '0;
         grant <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q <= ptr_d;
         grant <= grant_d;
      end
   end
   always_comb begin
      for (int o = 0; o < NPORT; o++) out_busy[o] = state_q[o] == BUSY;
   end
   assign sel = owner_q;
endmodule

// File: doc/router_xbar_sched.md
# router_xbar_sched

Crossbar scheduler for the 16x16 router. Each input-port engine, once it has deserialized a packet's destination address, raises a request toward one output port. The scheduler runs an independent round-robin arbiter per output and locks each grant for the full packet. It drives the crossbar select lines and releases an output when the owning input signals end of packet.

## Interface
- NPORT, 16, number of input and output ports
- AW, 4, port index width; equals clog2(NPORT)
- clk  input  1  router clock; all state updates on the rising edge
- reset_n  input  1  asynchronous active-low reset
- req  input  NPORT  input i has a header decoded and is waiting for, or holding, an output
- req_dst  input  NPORT*AW  destination output of input i in bits [i*AW +: AW]; sampled only while req[i]=1
- done  input  NPORT  one-cycle pulse from input i on the cycle its last data bit leaves (frameo_n rising)
- grant  output  NPORT  input i currently owns an output
- out_busy  output  NPORT  output o is locked to an input
- sel  output  NPORT*AW  for output o, the index of the owning input in bits [o*AW +: AW]; don't-care unless out_busy[o]=1

## Operation
- Per output o, two states: IDLE and BUSY.
- Registered state per output: state, owner index, round-robin pointer ptr[o].
- IDLE candidates: all i with req[i]=1, req_dst[i]=o and grant[i]=0.
- IDLE pick: the first candidate at or after ptr[o], searching upward modulo NPORT.
- On a pick, the next state is BUSY:
  - owner=i, grant[i]=1, out_busy[o]=1
  - ptr[o]=(i+1) mod NPORT, so the winner becomes lowest priority
- IDLE with no candidates: stay IDLE; ptr[o] is unchanged.
- BUSY: hold the owner regardless of req[owner]. Deasserting req does not release the output.
- BUSY, done[owner]=1: the next state is IDLE, grant[owner]=0, out_busy[o]=0. ptr[o] is unchanged.
- done[i] while grant[i]=0: ignored.
- done from a non-owner input: ignored.
- An input has only one req_dst, so it competes for one output at a time. Outputs never contend for the same input.
- All NPORT arbiters evaluate in parallel. Any number of outputs may grant in the same cycle.
- Index arithmetic is unsigned AW bits. ptr wrap from 15 to 0 is the natural AW-bit overflow.

## Timing
- Reset values (asynchronous, immediate): grant=0, out_busy=0, sel=0, all states IDLE, all ptr=0.
- Grant latency: a request sampled at edge N produces grant, out_busy and sel valid after edge N+1. That is one cycle, registered outputs only.
- Release latency: done sampled at edge N clears grant and out_busy after edge N+1.
- Re-arbitration on an output happens no earlier than the edge after release. There is exactly one idle bubble between back-to-back packets on the same output, even if a candidate was waiting during the done cycle.
- The releasing input may win again in the next arbitration, but only if no other candidate is present. The pointer has already passed it.
- sel[o] is stable for the whole BUSY interval. It changes only on an IDLE-to-BUSY transition.
- A reset_n assertion mid-packet drops all grants asynchronously. The first arbitration after deassertion starts from ptr=0.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package router_pkg contains:
  - NPORT, AW
  - port_id_t (logic [AW-1:0])
  - out_state_e {IDLE, BUSY}
- Sub-module router_rr_arb is purely combinational.
  - Inputs: NPORT-bit candidate vector and ptr.
  - Outputs: one-hot gnt, gnt_idx, gnt_valid.
  - Implement with a double-width rotate-and-priority-encode.
  - Instantiated NPORT times in router_xbar_sched, via a generate loop.
- The top contains candidate masking, the per-output state and owner registers, the ptr registers, and the grant OR-reduction across outputs.

## Test plan
- Single request: req[3]=1, req_dst[3]=5. One cycle later, grant[3]=1, out_busy[5]=1, sel[5]=3, ptr[5]=4. Pulse done[3] and expect grant[3]=0 and out_busy[5]=0 one cycle later.
- Contention: inputs 0, 7 and 12 all request output 2, each pulsing done 20 cycles after its grant. Expect the grant order 0, 7, 12 with one bubble between grants, ending with ptr[2]=13.
- Wrap fairness: with ptr[2]=13, inputs 1 and 14 request output 2. Expect 14 to be granted first, then 1 after done[14]. ptr[2] ends at 2.
- Parallel outputs: inputs 1→4, 2→9 and 15→0 are raised in the same cycle. All three grants appear together after one cycle, with sel[4]=1, sel[9]=2, sel[0]=15.
- Spurious and overlapping events:
  - done[6] while input 6 is ungranted causes no change.
  - req[3] dropped mid-packet keeps the grant.
  - done[3] in the same cycle as a new req[8]→5 gives release, one idle cycle, then grant[8].
- Reset mid-packet: assert reset_n low while outputs 5 and 9 are busy. grant, out_busy and sel clear immediately without a clock edge. After release, requests from inputs 2 and 0 to output 5 grant input 0 first.
